// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper axis: FSM state encoding and default widths.
package stepper_pkg;

  localparam int DEF_STEP_W = 32;
  localparam int DEF_PER_W  = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HI   = 2'd1,
    S_LO   = 2'd2,
    S_HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/stepper_ramp.sv
// Speed ramp for the stepper axis: owns the current half-period, the count of
// accelerating steps and the phase timer that strobes phase_end.
module stepper_ramp
  import stepper_pkg::*;
#(
  parameter int STEP_W = DEF_STEP_W,
  parameter int PER_W  = DEF_PER_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              run,
  input  logic              advance,
  input  logic              step_done,
  input  logic              decel,
  input  logic [PER_W-1:0]  per_start,
  input  logic [PER_W-1:0]  per_cruise,
  input  logic [PER_W-1:0]  accel,
  output logic [STEP_W-1:0] ramp_cnt,
  output logic              phase_end
);

  logic [PER_W-1:0] cur_per;
  logic [PER_W-1:0] top_per;
  logic [PER_W-1:0] cruise_per;
  logic [PER_W-1:0] acc_per;
  logic [PER_W-1:0] cnt;
  logic [PER_W-1:0] eff_per;
  logic [PER_W-1:0] per_dn;
  logic [PER_W-1:0] per_up;

  // Faster: subtract without wrapping below zero, never below cruise.
  function automatic logic [PER_W-1:0] ramp_down(input logic [PER_W-1:0] cur,
                                                 input logic [PER_W-1:0] dec,
                                                 input logic [PER_W-1:0] floor);
    if (cur > dec && (cur - dec) > floor) return cur - dec;
    return floor;
  endfunction

  // Slower: add with one guard bit, never above the start half-period.
  function automatic logic [PER_W-1:0] ramp_up(input logic [PER_W-1:0] cur,
                                               input logic [PER_W-1:0] inc,
                                               input logic [PER_W-1:0] ceil);
    logic [PER_W:0] sum;
    sum = {1'b0, cur} + {1'b0, inc};
    if (sum > {1'b0, ceil}) return ceil;
    return sum[PER_W-1:0];
  endfunction

  assign eff_per   = (cur_per == '0) ? PER_W'(1) : cur_per;
  assign phase_end = (cnt >= eff_per);
  assign per_dn    = ramp_down(cur_per, acc_per, cruise_per);
  assign per_up    = ramp_up(cur_per, acc_per, top_per);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_per    <= '0;
      top_per    <= '0;
      cruise_per <= '0;
      acc_per    <= '0;
      ramp_cnt   <= '0;
      cnt        <= '0;
    end else if (load) begin
      top_per    <= (per_start > per_cruise) ? per_start : per_cruise;
      cur_per    <= (per_start > per_cruise) ? per_start : per_cruise;
      cruise_per <= per_cruise;
      acc_per    <= accel;
      ramp_cnt   <= '0;
      cnt        <= PER_W'(1);
    end else begin
      if (advance) cnt <= PER_W'(1);
      else if (run) cnt <= cnt + PER_W'(1);
      if (step_done) begin
        if (decel) begin
          cur_per <= per_up;
        end else begin
          cur_per <= per_dn;
          if (per_dn < cur_per) ramp_cnt <= ramp_cnt + STEP_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/stepper_axis.sv
// Single-axis step/dir generator with trapezoidal ramp, endstops, homing and abort.
module stepper_axis
  import stepper_pkg::*;
#(
  parameter int STEP_W = DEF_STEP_W,
  parameter int PER_W  = DEF_PER_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     home_mode,
  input  logic [STEP_W-1:0]        step_cmd,
  input  logic [PER_W-1:0]         per_cruise,
  input  logic [PER_W-1:0]         per_start,
  input  logic [PER_W-1:0]         accel,
  input  logic                     lim_min,
  input  logic                     lim_max,
  output logic                     step,
  output logic                     dir,
  output logic                     busy,
  output logic                     done,
  output logic                     limit_hit,
  output logic signed [STEP_W-1:0] remaining,
  output logic signed [STEP_W-1:0] pos
);

  localparam logic signed [STEP_W-1:0] ONE = STEP_W'(1);

  state_t                   state;
  logic                     home;
  logic                     blocked;
  logic                     blocked_cmd;
  logic                     accept;
  logic                     in_move;
  logic                     phase_end;
  logic                     step_done;
  logic                     decel;
  logic signed [STEP_W-1:0] pos_next;
  logic signed [STEP_W-1:0] rem_next;
  logic [STEP_W-1:0]        rem_mag;
  logic [STEP_W-1:0]        ramp_cnt;

  assign blocked     = (lim_min & dir) | (lim_max & ~dir);
  assign blocked_cmd = (lim_min & step_cmd[STEP_W-1]) | (lim_max & ~step_cmd[STEP_W-1]);
  assign accept      = (state == S_IDLE) & start & ~blocked_cmd &
                       ((step_cmd != '0) | home_mode);
  assign in_move     = (state == S_HI) | (state == S_LO);
  assign step_done   = (state == S_LO) & start & ~blocked & phase_end;

  assign pos_next = dir ? (pos - ONE) : (pos + ONE);
  assign rem_next = home ? remaining : (dir ? (remaining + ONE) : (remaining - ONE));
  assign rem_mag  = rem_next[STEP_W-1] ? -rem_next : rem_next;
  // Decelerate once the steps left fit inside the distance spent accelerating.
  assign decel    = ~home & (rem_mag <= ramp_cnt);

  stepper_ramp #(
    .STEP_W (STEP_W),
    .PER_W  (PER_W)
  ) u_ramp (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .run        (in_move),
    .advance    (in_move & phase_end),
    .step_done  (step_done),
    .decel      (decel),
    .per_start  (per_start),
    .per_cruise (per_cruise),
    .accel      (accel),
    .ramp_cnt   (ramp_cnt),
    .phase_end  (phase_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      step      <= 1'b0;
      dir       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      limit_hit <= 1'b0;
      remaining <= '0;
      pos       <= '0;
      home      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state     <= S_HI;
            step      <= 1'b1;
            busy      <= 1'b1;
            dir       <= step_cmd[STEP_W-1];
            home      <= home_mode;
            remaining <= step_cmd;
            limit_hit <= 1'b0;
          end
        end
        S_HI: begin
          if (!start) begin
            state <= S_IDLE;
            step  <= 1'b0;
            busy  <= 1'b0;
          end else if (blocked) begin
            // The pulse already out is counted as a completed step.
            state     <= S_HOLD;
            step      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            limit_hit <= 1'b1;
            remaining <= rem_next;
            pos       <= home ? '0 : pos_next;
          end else if (phase_end) begin
            state <= S_LO;
            step  <= 1'b0;
          end
        end
        S_LO: begin
          if (!start) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (blocked) begin
            state     <= S_HOLD;
            busy      <= 1'b0;
            done      <= 1'b1;
            limit_hit <= 1'b1;
            if (home) pos <= '0;
          end else if (phase_end) begin
            pos       <= pos_next;
            remaining <= rem_next;
            if (!home && rem_next == '0) begin
              state <= S_HOLD;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_HI;
              step  <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (!start) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_axis.sv
// Bench for stepper_axis: behavioural move model checked every cycle, directed
// scenarios with literal expectations, then randomized moves.
module tb_stepper_axis;

  localparam int SW = 32;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          home_mode = 1'b0;
  logic [SW-1:0] step_cmd = '0;
  logic [PW-1:0] per_cruise = '0;
  logic [PW-1:0] per_start = '0;
  logic [PW-1:0] accel = '0;
  logic          lim_min = 1'b0;
  logic          lim_max = 1'b0;
  logic          step, dir, busy, done, limit_hit;
  logic [SW-1:0] remaining, pos;

  always #5 clk = ~clk;

  stepper_axis #(.STEP_W(SW), .PER_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .home_mode(home_mode), .step_cmd(step_cmd),
    .per_cruise(per_cruise), .per_start(per_start), .accel(accel),
    .lim_min(lim_min), .lim_max(lim_max), .step(step), .dir(dir), .busy(busy),
    .done(done), .limit_hit(limit_hit), .remaining(remaining), .pos(pos)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic signed [63:0] act,
                                input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: a move is a sequence of pulses, each a high and a low
  // half-period; the half-period follows the ramp rule after each full step.
  typedef enum {M_IDLE, M_MOVE, M_WAIT} mmode_t;
  mmode_t m_mode = M_IDLE;
  bit     m_high = 0, m_dir = 0, m_home = 0, m_done = 0, m_lim = 0;
  longint m_rem = 0, m_pos = 0, m_per = 0, m_top = 0, m_cruise = 0, m_acc = 0;
  longint m_nacc = 0, m_left = 0;

  function automatic longint eff(input longint p);
    return (p == 0) ? 1 : p;
  endfunction

  task automatic m_count_step();
    m_pos += m_dir ? -1 : 1;
    if (!m_home) m_rem += m_dir ? 1 : -1;
  endtask

  task automatic m_ramp();
    longint nxt;
    longint mag;
    mag = (m_rem < 0) ? -m_rem : m_rem;
    if (!m_home && mag <= m_nacc) begin
      m_per = (m_per + m_acc > m_top) ? m_top : m_per + m_acc;
    end else begin
      nxt = m_per - m_acc;
      if (nxt < m_cruise) nxt = m_cruise;
      if (nxt < m_per) m_nacc++;
      m_per = nxt;
    end
  endtask

  task automatic model_edge();
    bit blk;
    bit d;
    m_done = 0;
    if (rst) begin
      m_mode = M_IDLE; m_high = 0; m_dir = 0; m_home = 0; m_lim = 0;
      m_rem = 0; m_pos = 0; m_nacc = 0;
      return;
    end
    blk = m_dir ? lim_min : lim_max;
    case (m_mode)
      M_IDLE: begin
        d = step_cmd[SW-1];
        if (start && !(d ? lim_min : lim_max) && (step_cmd != 0 || home_mode)) begin
          m_mode = M_MOVE; m_high = 1; m_dir = d; m_home = home_mode; m_lim = 0;
          m_rem = longint'($signed(step_cmd));
          m_top = (per_start > per_cruise) ? longint'(per_start) : longint'(per_cruise);
          m_per = m_top; m_cruise = longint'(per_cruise); m_acc = longint'(accel);
          m_nacc = 0; m_left = eff(m_per);
        end
      end
      M_MOVE: begin
        if (!start) begin
          m_mode = M_IDLE;
        end else if (blk) begin
          if (m_high) m_count_step();
          if (m_home) m_pos = 0;
          m_mode = M_WAIT; m_done = 1; m_lim = 1;
        end else if (m_left > 1) begin
          m_left--;
        end else if (m_high) begin
          m_high = 0; m_left = eff(m_per);
        end else begin
          m_count_step();
          if (!m_home && m_rem == 0) begin
            m_mode = M_WAIT; m_done = 1;
          end else begin
            m_ramp();
            m_high = 1; m_left = eff(m_per);
          end
        end
      end
      M_WAIT: if (!start) m_mode = M_IDLE;
      default: m_mode = M_IDLE;
    endcase
  endtask

  int pulses = 0, hi_run = 0, done_cnt = 0;
  int hi_q[$];
  bit prev_step = 0;

  always @(posedge clk) begin
    model_edge();
    #1;
    check("step", step, (m_mode == M_MOVE) && m_high);
    check("busy", busy, m_mode == M_MOVE);
    check("dir", dir, m_dir);
    check("done", done, m_done);
    check("limit_hit", limit_hit, m_lim);
    check("remaining", $signed(remaining), m_rem);
    check("pos", $signed(pos), m_pos);
    if (step === 1'b1) begin
      if (!prev_step) pulses++;
      hi_run++;
    end else if (prev_step) begin
      hi_q.push_back(hi_run);
      hi_run = 0;
    end
    if (done === 1'b1) done_cnt++;
    prev_step = (step === 1'b1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1; start = 0; home_mode = 0; lim_min = 0; lim_max = 0; step_cmd = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    pulses = 0; done_cnt = 0; hi_q.delete();
  endtask

  task automatic wait_done(input int bound, input string tag);
    int i;
    for (i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check({tag, "_done_seen"}, i < bound, 1);
  endtask

  task automatic set_per(input int ps, input int pc, input int ac);
    per_start = PW'(ps); per_cruise = PW'(pc); accel = PW'(ac);
  endtask

  int exp3[20] = '{10, 8, 6, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 6, 8, 10};

  initial begin
    int seen;
    int i;
    // Reset values
    do_reset();
    check("rst_step", step, 0);       check("rst_dir", dir, 0);
    check("rst_busy", busy, 0);       check("rst_done", done, 0);
    check("rst_limit", limit_hit, 0); check("rst_rem", $signed(remaining), 0);
    check("rst_pos", $signed(pos), 0);

    // Five steps at a constant 3-clock half-period
    step_cmd = SW'(5); set_per(3, 3, 0); start = 1;
    wait_done(200, "t1");
    check("t1_pulses", pulses, 5);
    check("t1_pos", $signed(pos), 5);
    check("t1_rem", $signed(remaining), 0);
    check("t1_limit", limit_hit, 0);
    check("t1_hi_count", hi_q.size(), 5);
    foreach (hi_q[k]) check("t1_hi_len", hi_q[k], 3);
    @(negedge clk); @(negedge clk);
    check("t1_done_cnt", done_cnt, 1);
    start = 0; @(negedge clk);

    // Negative move stopped by lim_min during the third high phase
    do_reset();
    step_cmd = SW'(-4); set_per(3, 3, 0); start = 1;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (step && pulses == 3) lim_min = 1;
      if (done) break;
    end
    check("t2_done_seen", i < 200, 1);
    check("t2_pulses", pulses, 3);
    check("t2_pos", $signed(pos), -3);
    check("t2_rem", $signed(remaining), -1);
    check("t2_limit", limit_hit, 1);
    check("t2_dir", dir, 1);
    start = 0; lim_min = 0; @(negedge clk);

    // Trapezoidal ramp 10 -> 4 -> 10
    do_reset();
    step_cmd = SW'(20); set_per(10, 4, 2); start = 1;
    wait_done(2000, "t3");
    check("t3_hi_count", hi_q.size(), 20);
    for (int k = 0; k < 20 && k < hi_q.size(); k++) check("t3_hi_len", hi_q[k], exp3[k]);
    check("t3_ramp_cnt", dut.u_ramp.ramp_cnt, 3);
    check("t3_pos", $signed(pos), 20);
    start = 0; @(negedge clk);

    // Homing toward lim_min, endstop at the seventh step
    do_reset();
    home_mode = 1; step_cmd = SW'(-1); set_per(2, 2, 0); start = 1;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (step && pulses == 7) lim_min = 1;
      if (done) break;
    end
    check("t4_done_seen", i < 300, 1);
    check("t4_pulses", pulses, 7);
    check("t4_pos", $signed(pos), 0);
    check("t4_limit", limit_hit, 1);
    lim_min = 0; home_mode = 0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (step || busy) seen++;
    end
    check("t4_hold_no_restart", seen, 0);
    start = 0; @(negedge clk); @(negedge clk);

    // Abort during the low phase of step 2 of 6
    do_reset();
    step_cmd = SW'(6); set_per(3, 3, 0); start = 1;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pulses == 2 && !step) begin
        start = 0;
        break;
      end
    end
    @(negedge clk);
    check("t5_step", step, 0);
    check("t5_busy", busy, 0);
    check("t5_rem", $signed(remaining), 5);
    check("t5_pos", $signed(pos), 1);
    check("t5_done_cnt", done_cnt, 0);

    // Blocked at start, then reset in the middle of a move
    do_reset();
    lim_max = 1; step_cmd = SW'(3); set_per(2, 2, 0); start = 1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy) seen++;
    end
    check("t6_never_busy", seen, 0);
    start = 0; lim_max = 0; @(negedge clk);
    step_cmd = SW'(-10); start = 1;
    for (int k = 0; k < 7; k++) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("t6_rst_step", step, 0);   check("t6_rst_dir", dir, 0);
    check("t6_rst_busy", busy, 0);   check("t6_rst_limit", limit_hit, 0);
    check("t6_rst_rem", $signed(remaining), 0);
    check("t6_rst_pos", $signed(pos), 0);
    check("t6_rst_ramp", dut.u_ramp.ramp_cnt, 0);
    rst = 0; start = 0; @(negedge clk);

    // Randomized moves, limits and aborts against the model
    for (int mv = 0; mv < 60; mv++) begin
      @(negedge clk);
      step_cmd  = SW'(int'($urandom_range(24)) - 12);
      home_mode = ($urandom_range(7) == 0);
      set_per(int'($urandom_range(5)), int'($urandom_range(4)), int'($urandom_range(3)));
      start = 1;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if ($urandom_range(40) == 0) lim_min = ~lim_min;
        if ($urandom_range(40) == 0) lim_max = ~lim_max;
        if (busy) begin
          step_cmd = $urandom;
          set_per(int'($urandom_range(9)), int'($urandom_range(9)), int'($urandom_range(9)));
          home_mode = $urandom_range(1) == 1;
        end
        if ($urandom_range(150) == 0) start = 0;
        if (done || !start) break;
      end
      start = 0;
      @(negedge clk);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stepper_axis.md
STEPPER_AXIS -- requirements
Module: stepper_axis

Interface
REQ-001 SHALL have parameter STEP_W, default 32: width of the signed step command, remaining count and position.
REQ-002 SHALL have parameter PER_W, default 32: width of all half-period and acceleration values, in clocks.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  level request; a rise starts a move, a drop aborts it.
REQ-006 SHALL have port home_mode  input  1  sampled at start; selects homing instead of a counted move.
REQ-007 SHALL have port step_cmd  input  STEP_W  two's-complement step count; MSB=1 is the negative direction.
REQ-008 SHALL have port per_cruise  input  PER_W  cruise half-period.
REQ-009 SHALL have port per_start  input  PER_W  start/stop half-period.
REQ-010 SHALL have port accel  input  PER_W  half-period change applied per completed step.
REQ-011 SHALL have ports lim_min and lim_max  input  1 each  endstops.
REQ-012 SHALL have port step  output  1  step pulse.
REQ-013 SHALL have port dir  output  1  latched sign of step_cmd.
REQ-014 SHALL have port busy  output  1  move in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse when a move ends.
REQ-016 SHALL have port limit_hit  output  1  the last move ended on an endstop.
REQ-017 SHALL have port remaining  output  STEP_W  signed steps left.
REQ-018 SHALL have port pos  output  STEP_W  signed absolute position.

Function
REQ-019 SHALL implement FSM IDLE -> HI -> LO -> (HI | HOLD) -> IDLE.
REQ-020 SHALL define "blocked" as (lim_min & dir=1) | (lim_max & dir=0).
REQ-021 In IDLE, when start=1 and blocked=0 (evaluated with the dir of step_cmd) and (step_cmd!=0 | home_mode=1), SHALL latch the command and set cur_per=max(per_start, per_cruise).
REQ-022 SHALL assert step and busy on the cycle after the accepting edge.
REQ-023 SHALL hold each HI and LO phase for cur_per clocks; cur_per=0 SHALL be treated as 1.
REQ-024 A step SHALL complete at the end of LO: pos moves ±1 toward dir, and remaining moves 1 toward 0 in counted mode.
REQ-025 Ramp, after each completed step: while accelerating, cur_per=max(cur_per-accel, per_cruise) with no underflow, and ramp_cnt counts the steps that reduced cur_per.
REQ-026 Ramp, counted mode: once |remaining| <= ramp_cnt, cur_per=min(cur_per+accel, start value); homing mode SHALL never decelerate.
REQ-027 A counted move whose remaining reaches 0 SHALL go to HOLD with done=1 for one cycle and limit_hit=0.
REQ-028 On blocked during HI, step SHALL drop on the next cycle and the step SHALL count as completed; on blocked during LO, the move SHALL stop at once. Either way: HOLD, done=1, limit_hit=1.
REQ-029 A homing move SHALL end only via REQ-028, and pos SHALL be cleared to 0 on that cycle.
REQ-030 In HOLD, the FSM SHALL return to IDLE only after start=0 (no restart without a new rise).
REQ-031 On start=0 in HI/LO, SHALL abort to IDLE next cycle with step=0, busy=0, no done, remaining and pos frozen, and no partial step counted.
REQ-032 Command inputs SHALL be ignored while busy.

Reset
REQ-033 On rst=1, SHALL set state=IDLE, step=0, dir=0, busy=0, done=0, limit_hit=0, remaining=0, pos=0, and clear the ramp registers.
REQ-034 rst mid-move SHALL drop step in the following cycle; rst SHALL take priority over all other inputs.

Structure
REQ-035 Package stepper_pkg SHALL hold the FSM state encoding and the default STEP_W/PER_W constants.
REQ-036 Sub-module stepper_ramp SHALL own cur_per, ramp_cnt and the phase counter, and SHALL emit a phase-end strobe.

Verification
REQ-037 step_cmd=5, per_start=per_cruise=3, accel=0 -> 5 pulses, 3 high/3 low clocks each, pos=5, remaining=0, one done pulse.
REQ-038 step_cmd=-4, lim_min rising during the 3rd HI -> 3 steps counted, pos=-3, remaining=-1, limit_hit=1.
REQ-039 step_cmd=20, per_start=10, per_cruise=4, accel=2 -> half-periods 10,8,6,4,...,4,6,8,10; ramp_cnt=3.
REQ-040 home_mode=1, step_cmd=-1, lim_min at step 7 -> pos=0, done pulse, FSM waits in HOLD until start=0.
REQ-041 start dropped mid-LO of step 2 of 6 -> step=0, busy=0 next cycle, remaining=5, no done pulse.
REQ-042 start=1 with lim_max=1 and step_cmd=+3 -> never busy; rst asserted mid-move -> all outputs at reset values next cycle.
